draw_ball_pixel: RTL and testbench
==================================

// Module: draw_ball_pixel
// PURPOSE
//  Pixel-stream stage downstream of the ball position generators (draw_ball_x/draw_ball_y).
//  Consumes ball centre coordinates and overlays a filled circular ball onto the VGA timing/RGB stream.
//  Ball position is sampled once per frame, at the start of vertical blanking, so the ball never tears.
//  All timing signals are delayed to match the 2-cycle RGB pipeline.
// PARAMETERS
//  RADIUS      8        ball radius in pixels, 1..31
//  BALL_COLOR  12'hF_F_F ball RGB 4:4:4 colour
//  X_INIT      512      latched centre X after reset
//  Y_INIT      30       latched centre Y after reset
// PORTS
//  pclk       in   1   pixel clock, all logic on rising edge
//  reset      in   1   asynchronous, active-low reset (0 = reset)
//  x_pos      in   12  ball centre X from position generator, unsigned
//  y_pos      in   12  ball centre Y from position generator, unsigned
//  hcount_in  in   11  current pixel X
//  vcount_in  in   11  current pixel Y
//  hsync_in   in   1   horizontal sync
//  vsync_in   in   1   vertical sync
//  hblnk_in   in   1   horizontal blank
//  vblnk_in   in   1   vertical blank
//  rgb_in     in   12  background pixel colour
//  hcount_out out  11  hcount_in delayed 2 cycles
//  vcount_out out  11  vcount_in delayed 2 cycles
//  hsync_out  out  1   hsync_in delayed 2 cycles
//  vsync_out  out  1   vsync_in delayed 2 cycles
//  hblnk_out  out  1   hblnk_in delayed 2 cycles
//  vblnk_out  out  1   vblnk_in delayed 2 cycles
//  rgb_out    out  12  composited colour, 2-cycle latency
// BEHAVIOUR
//  Reset (async assert, sync deassert to pclk): all outputs and pipeline regs 0.
//   x_lat=X_INIT, y_lat=Y_INIT, vblnk_d=0.
//  Frame latch FSM, 2 states:
//   ACTIVE: on vblnk_in rising edge (vblnk_in=1 and vblnk_d=0), load x_lat<=x_pos, y_lat<=y_pos.
//    Move to BLANK.
//   BLANK: hold latch. Return to ACTIVE when vblnk_in=0.
//   x_lat/y_lat never change while vblnk_in=0. x_pos/y_pos changes mid-frame are ignored.
//  Stage 1 (registered):
//   dx = {2'b0,hcount_in} - {1'b0,x_lat}, 13-bit signed.
//   dy = {2'b0,vcount_in} - {1'b0,y_lat}, 13-bit signed.
//   sq_x = dx*dx and sq_y = dy*dy, 26-bit unsigned. Register these with all timing/rgb inputs.
//  Stage 2 (registered):
//   hit = (sq_x + sq_y) <= RADIUS*RADIUS, using a 27-bit sum with no overflow.
//   If hit and !hblnk_s1 and !vblnk_s1: rgb_out=BALL_COLOR, else rgb_out=rgb_s1.
//  Latency: input at cycle n appears on all outputs at cycle n+2. The outputs stay mutually aligned.
//  Edge clipping: a ball partly off-screen (e.g. y_lat=0, or x_lat>1023) draws only its visible part.
//   Signed dx/dy rule out any wrap-around artefacts.
//  Blanking pixels always pass rgb_in unchanged.
//  Reset mid-frame: outputs drop to 0 at once. The next frame uses X_INIT/Y_INIT until the first
//   vblnk rising edge after reset release.
//  If the vblnk rising edge and reset release fall on the same edge, reset wins and nothing is latched.
// TESTING
//  T1 reset: reset=0, drive inputs -> all outputs 0; release -> x_lat=512, y_lat=30.
//  T2 latency: hsync_in pulse at cycle 10 -> hsync_out pulse at cycle 12; same for hcount/vcount/blank.
//  T3 draw: x_pos=100, y_pos=100, one vblnk edge, RADIUS=8.
//   Pixel (100,100)->FFF; (108,100)->FFF; (109,100)->rgb_in; (106,106)->rgb_in (72>64).
//  T4 frame latch: change y_pos 100->200 mid-frame -> ball stays at y=100.
//   It moves to y=200 only after the next vblnk rising edge.
//  T5 clipping: x_pos=0, y_pos=0 -> pixels (0..8,0) FFF, no ball at hcount 1020..1023 or vcount 760+.
//  T6 blanking: ball centre inside region but hblnk_in=1 -> rgb_out equals delayed rgb_in.

Source files
------------

// File: rtl/draw_ball_pixel.sv
// Overlays a filled circular ball onto a VGA timing/RGB stream.
// The ball centre is sampled once per frame at the start of vertical blanking; all outputs have 2-cycle latency.
module draw_ball_pixel #(
  parameter int unsigned RADIUS     = 8,
  parameter logic [11:0] BALL_COLOR = 12'hFFF,
  parameter int unsigned X_INIT     = 512,
  parameter int unsigned Y_INIT     = 30
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int unsigned POS_W  = 12;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned DIFF_W = 13;
  localparam int unsigned SQ_W   = 26;
  localparam int unsigned SUM_W  = 27;
  localparam int unsigned R_SQ   = RADIUS * RADIUS;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_BLANK  = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_vblnk_d;
  logic [POS_W-1:0]   r_x_lat;
  logic [POS_W-1:0]   r_y_lat;

  logic [SQ_W-1:0]    r_sq_x;
  logic [SQ_W-1:0]    r_sq_y;
  logic [CNT_W-1:0]   r_hcount_s1;
  logic [CNT_W-1:0]   r_vcount_s1;
  logic               r_hsync_s1;
  logic               r_vsync_s1;
  logic               r_hblnk_s1;
  logic               r_vblnk_s1;
  logic [11:0]        r_rgb_s1;

  logic signed [DIFF_W-1:0] w_dx;
  logic signed [DIFF_W-1:0] w_dy;
  logic signed [SQ_W-1:0]   w_dx_ext;
  logic signed [SQ_W-1:0]   w_dy_ext;
  logic signed [SQ_W-1:0]   w_sq_x;
  logic signed [SQ_W-1:0]   w_sq_y;
  logic [SUM_W-1:0]         w_sum;
  logic                     w_hit;

  // Frame latch: centre captured only on the rising edge of vertical blank
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_ACTIVE;
      r_vblnk_d <= 1'b0;
      r_x_lat   <= POS_W'(X_INIT);
      r_y_lat   <= POS_W'(Y_INIT);
    end else begin
      r_vblnk_d <= vblnk_in;
      case (r_state)
        ST_ACTIVE: begin
          if (vblnk_in && !r_vblnk_d) begin
            r_x_lat <= x_pos;
            r_y_lat <= y_pos;
            r_state <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (!vblnk_in) begin
            r_state <= ST_ACTIVE;
          end
        end
      endcase
    end
  end

  // Signed distances keep off-screen centres from wrapping onto the visible area
  assign w_dx     = $signed({2'b00, hcount_in}) - $signed({1'b0, r_x_lat});
  assign w_dy     = $signed({2'b00, vcount_in}) - $signed({1'b0, r_y_lat});
  assign w_dx_ext = SQ_W'(w_dx);
  assign w_dy_ext = SQ_W'(w_dy);
  assign w_sq_x   = w_dx_ext * w_dx_ext;
  assign w_sq_y   = w_dy_ext * w_dy_ext;

  // Stage 1: squared distances plus aligned timing/colour
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_sq_x      <= '0;
      r_sq_y      <= '0;
      r_hcount_s1 <= '0;
      r_vcount_s1 <= '0;
      r_hsync_s1  <= 1'b0;
      r_vsync_s1  <= 1'b0;
      r_hblnk_s1  <= 1'b0;
      r_vblnk_s1  <= 1'b0;
      r_rgb_s1    <= '0;
    end else begin
      r_sq_x      <= SQ_W'($unsigned(w_sq_x));
      r_sq_y      <= SQ_W'($unsigned(w_sq_y));
      r_hcount_s1 <= hcount_in;
      r_vcount_s1 <= vcount_in;
      r_hsync_s1  <= hsync_in;
      r_vsync_s1  <= vsync_in;
      r_hblnk_s1  <= hblnk_in;
      r_vblnk_s1  <= vblnk_in;
      r_rgb_s1    <= rgb_in;
    end
  end

  assign w_sum = {1'b0, r_sq_x} + {1'b0, r_sq_y};
  assign w_hit = (w_sum <= SUM_W'(R_SQ));

  // Stage 2: composite, never painting over blanking
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= r_hcount_s1;
      vcount_out <= r_vcount_s1;
      hsync_out  <= r_hsync_s1;
      vsync_out  <= r_vsync_s1;
      hblnk_out  <= r_hblnk_s1;
      vblnk_out  <= r_vblnk_s1;
      rgb_out    <= (w_hit && !r_hblnk_s1 && !r_vblnk_s1) ? BALL_COLOR : r_rgb_s1;
    end
  end

endmodule

// File: tb/tb_draw_ball_pixel.sv
// Directed plus randomized bench for draw_ball_pixel against a per-pixel circle/frame-latch model.
module tb_draw_ball_pixel;

  localparam int R = 8;

  logic        pclk = 1'b0;
  logic        reset;
  logic [11:0] x_pos, y_pos;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [37:0] outs;

  int checks = 0;
  int failures = 0;

  // model state: centre used for the current frame, previous vblank level
  int mx, my;
  bit mvd;
  logic [37:0] exp_q[$];

  always #5 pclk = ~pclk;

  draw_ball_pixel dut (
    .pclk(pclk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  assign outs = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};

  function automatic logic [37:0] model();
    int dx, dy;
    logic [11:0] c;
    dx = int'(hcount_in) - mx;
    dy = int'(vcount_in) - my;
    c  = (dx * dx + dy * dy <= R * R && !hblnk_in && !vblnk_in) ? 12'hFFF : rgb_in;
    return {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, c};
  endfunction

  task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
    checks++;
    assert (got[37:12] === exp[37:12]) else begin
      failures++;
      $error("FAIL %s timing got=%h exp=%h", tag, got[37:12], exp[37:12]);
    end
    checks++;
    assert (got[11:0] === exp[11:0]) else begin
      failures++;
      $error("FAIL %s rgb (h=%0d v=%0d) got=%h exp=%h", tag, exp[37:27], exp[26:16], got[11:0], exp[11:0]);
    end
  endtask

  // Present current inputs for one clock, then check the output due this cycle
  task automatic cycle(input string tag);
    if (reset) begin
      exp_q.push_back(model());
      if (vblnk_in && !mvd) begin
        mx = int'(x_pos);
        my = int'(y_pos);
      end
      mvd = vblnk_in;
    end else begin
      exp_q.delete();
      mx = 512; my = 30; mvd = 1'b0;
    end
    @(negedge pclk);
    if (!reset) check({tag, "_rst"}, outs, 38'd0);
    else if (exp_q.size() == 2) check(tag, outs, exp_q.pop_front());
  endtask

  task automatic px(input string tag, input int h, input int v, input bit hb, input bit vb);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'($urandom_range(0, 1));
    rgb_in    = 12'($urandom_range(0, 12'hFFE));
    cycle(tag);
  endtask

  task automatic vframe(input int n);
    for (int i = 0; i < n; i++) px("vbl", 1100, 800, 1'b1, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    x_pos = 12'd100; y_pos = 12'd100;
    hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;

    // T1: reset holds outputs at zero while inputs toggle; then initial centre in force
    for (int i = 0; i < 4; i++) px("t1", 512, 30, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) px("t1_init", 512 + i * 4, 30, 1'b0, 1'b0);
    px("t1_edge", 520, 30, 1'b0, 1'b0);
    px("t1_out", 521, 30, 1'b0, 1'b0);

    // T2: single-cycle sync/blank pulses
    for (int i = 0; i < 12; i++) px("t2", i, 5, (i == 10), 1'b0);

    // T3: draw at (100,100)
    vframe(3);
    px("t3_c", 100, 100, 1'b0, 1'b0);
    px("t3_r8", 108, 100, 1'b0, 1'b0);
    px("t3_r9", 109, 100, 1'b0, 1'b0);
    px("t3_diag", 106, 106, 1'b0, 1'b0);
    px("t3_l8", 92, 100, 1'b0, 1'b0);
    px("t3_up8", 100, 92, 1'b0, 1'b0);

    // T4: mid-frame position change is ignored until the next vblank edge
    y_pos = 12'd200;
    px("t4_old", 100, 100, 1'b0, 1'b0);
    px("t4_new", 100, 200, 1'b0, 1'b0);
    vframe(2);
    px("t4_moved", 100, 200, 1'b0, 1'b0);
    px("t4_gone", 100, 100, 1'b0, 1'b0);

    // T5: clipping at the origin and far edges
    x_pos = 12'd0; y_pos = 12'd0;
    vframe(2);
    for (int h = 0; h <= 9; h++) px("t5_row", h, 0, 1'b0, 1'b0);
    for (int h = 1020; h <= 1023; h++) px("t5_right", h, 0, 1'b0, 1'b0);
    for (int v = 760; v <= 767; v++) px("t5_bottom", 0, v, 1'b0, 1'b0);
    x_pos = 12'd1030; y_pos = 12'd4095;
    vframe(2);
    px("t5_xfar", 1023, 0, 1'b0, 1'b0);
    px("t5_yfar", 1030, 2047, 1'b0, 1'b0);

    // T6: blanking at the ball centre passes background
    x_pos = 12'd300; y_pos = 12'd300;
    vframe(2);
    px("t6_hb", 300, 300, 1'b1, 1'b0);
    px("t6_vb", 301, 300, 1'b0, 1'b1);
    px("t6_vis", 300, 300, 1'b0, 1'b0);
    px("t6_flush", 1100, 800, 1'b1, 1'b0);

    // Mid-frame reset: outputs clear immediately, next frame uses the initial centre
    reset = 1'b0;
    #1;
    check("midrst_async", outs, 38'd0);
    px("midrst", 300, 300, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) px("midrst_init", 510 + i, 31, 1'b0, 1'b0);
    px("midrst_old", 300, 300, 1'b0, 1'b0);

    // Randomized frames with jittering position inputs
    for (int i = 0; i < 4000; i++) begin
      int h, v;
      if ($urandom_range(0, 3) == 0) begin
        x_pos = 12'($urandom_range(0, 4095));
        y_pos = 12'($urandom_range(0, 4095));
      end else begin
        x_pos = 12'($urandom_range(0, 1100));
        y_pos = 12'($urandom_range(0, 800));
      end
      if ($urandom_range(0, 149) == 0) vblnk_in = ~vblnk_in;
      h = (mx + int'($urandom_range(0, 24)) - 12) & 2047;
      v = (my + int'($urandom_range(0, 24)) - 12) & 2047;
      if ($urandom_range(0, 15) == 0) h = int'($urandom_range(0, 2047));
      px("rand", h, v, ($urandom_range(0, 7) == 0), vblnk_in);
    end
    px("drain", 0, 0, 1'b0, 1'b0);
    px("drain", 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
